// File: rtl/sha256_avl_pkg.sv
// Shared definitions for the SHA-256 accelerator host:
// register map, host FSM states and the STATUS bit layout.
package sha256_avl_pkg;

  localparam logic [4:0] MSG_BASE    = 5'd0;
  localparam logic [4:0] CHAIN_ADDR  = 5'd16;
  localparam logic [4:0] H_BASE      = 5'd17;
  localparam logic [4:0] START_ADDR  = 5'd25;
  localparam logic [4:0] STATUS_ADDR = 5'd26;

  localparam int DONE_BIT = 0;

  typedef enum logic [2:0] {
    S_LOAD,
    S_CHAIN,
    S_START,
    S_POLL,
    S_PWAIT,
    S_RDDIG,
    S_RWAIT,
    S_OUT
  } state_e;

endpackage

// File: rtl/sha256_avl_if.sv
// Word-in / digest-out streams plus the Avalon-MM
// bus toward the accelerator register file.
interface sha256_avl_if;
  import sha256_avl_pkg::*;

  logic         IN_VALID;
  logic         IN_READY;
  logic [31:0]  IN_DATA;
  logic         IN_FIRST;
  logic         DIGEST_VALID;
  logic         DIGEST_READY;
  logic [255:0] DIGEST;
  logic         ERR;
  logic         AVL_READ;
  logic         AVL_WRITE;
  logic [4:0]   AVL_ADDR;
  logic [31:0]  AVL_WRITEDATA;
  logic [31:0]  AVL_READDATA;

  modport master (
    input  IN_VALID, IN_DATA, IN_FIRST,
    input  DIGEST_READY, AVL_READDATA,
    output IN_READY, DIGEST_VALID, DIGEST, ERR,
    output AVL_READ, AVL_WRITE, AVL_ADDR,
    output AVL_WRITEDATA
  );

  modport slave (
    output IN_VALID, IN_DATA, IN_FIRST,
    output DIGEST_READY, AVL_READDATA,
    input  IN_READY, DIGEST_VALID, DIGEST, ERR,
    input  AVL_READ, AVL_WRITE, AVL_ADDR,
    input  AVL_WRITEDATA
  );

endinterface

// File: rtl/sha256_avl_host.sv
// Host for the SHA-256 accelerator: loads a block,
// starts it, polls DONE and reads back the digest.
module sha256_avl_host
  import sha256_avl_pkg::*;
#(
  parameter int READ_LATENCY = 1,
  parameter int POLL_LIMIT   = 4096
) (
  input logic          CLK,
  input logic          RESET_N,
  sha256_avl_if.master bus
);

  localparam logic [7:0]  RL = 8'(READ_LATENCY);
  localparam logic [16:0] PL = 17'(POLL_LIMIT);

  state_e        state_q, state_d;
  logic [3:0]    idx_q, idx_d;
  logic [2:0]    k_q, k_d;
  logic [7:0]    lat_q, lat_d;
  logic [15:0]   poll_q, poll_d;
  logic [15:0]   poll_inc;
  logic          first_q, first_d;
  logic          err_q, err_d;
  logic          dv_q, dv_d;
  logic          rdy_q, rdy_d;
  logic          rd_q, rd_d;
  logic          wr_q, wr_d;
  logic [4:0]    addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [255:0]  dig_q, dig_d;
  logic          hs;
  logic [7:0]    sl;

  assign hs       = rdy_q & bus.IN_VALID;
  assign poll_inc = (poll_q == 16'hFFFF) ? poll_q
                                         : poll_q + 16'd1;
  assign sl       = {3'd7 - k_q, 5'd0};

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    k_d     = k_q;
    lat_d   = lat_q;
    poll_d  = poll_q;
    first_d = first_q;
    err_d   = err_q;
    dv_d    = dv_q;
    rd_d    = 1'b0;
    wr_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    dig_d   = dig_q;
    unique case (state_q)
      S_LOAD: begin
        if (hs) begin
          wr_d    = 1'b1;
          addr_d  = MSG_BASE + {1'b0, idx_q};
          wdata_d = bus.IN_DATA;
          idx_d   = idx_q + 4'd1;
          if (idx_q == 4'd0) begin
            first_d = bus.IN_FIRST;
            err_d   = 1'b0;
          end
          if (idx_q == 4'd15) state_d = S_CHAIN;
        end
      end
      S_CHAIN: begin
        wr_d    = 1'b1;
        addr_d  = CHAIN_ADDR;
        wdata_d = {31'b0, ~first_q};
        state_d = S_START;
      end
      S_START: begin
        wr_d    = 1'b1;
        addr_d  = START_ADDR;
        wdata_d = 32'd1;
        poll_d  = '0;
        state_d = S_POLL;
      end
      S_POLL: begin
        rd_d    = 1'b1;
        addr_d  = STATUS_ADDR;
        lat_d   = '0;
        state_d = S_PWAIT;
      end
      S_PWAIT: begin
        if (lat_q != RL) begin
          lat_d = lat_q + 8'd1;
        end else if (bus.AVL_READDATA[DONE_BIT]) begin
          k_d     = '0;
          state_d = S_RDDIG;
        end else begin
          poll_d = poll_inc;
          // a limit of zero means keep polling forever
          if (PL != 17'd0 && {1'b0, poll_inc} >= PL) begin
            err_d   = 1'b1;
            idx_d   = '0;
            state_d = S_LOAD;
          end else begin
            state_d = S_POLL;
          end
        end
      end
      S_RDDIG: begin
        rd_d    = 1'b1;
        addr_d  = H_BASE + {2'b0, k_q};
        lat_d   = '0;
        state_d = S_RWAIT;
      end
      S_RWAIT: begin
        if (lat_q != RL) begin
          lat_d = lat_q + 8'd1;
        end else begin
          dig_d[sl +: 32] = bus.AVL_READDATA;
          if (k_q == 3'd7) begin
            dv_d    = 1'b1;
            state_d = S_OUT;
          end else begin
            k_d     = k_q + 3'd1;
            state_d = S_RDDIG;
          end
        end
      end
      S_OUT: begin
        if (bus.DIGEST_READY) begin
          dv_d    = 1'b0;
          idx_d   = '0;
          state_d = S_LOAD;
        end
      end
      default: state_d = S_LOAD;
    endcase
    rdy_d = (state_d == S_LOAD);
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= S_LOAD;
      idx_q   <= '0;
      k_q     <= '0;
      lat_q   <= '0;
      poll_q  <= '0;
      first_q <= 1'b0;
      err_q   <= 1'b0;
      dv_q    <= 1'b0;
      rdy_q   <= 1'b0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      dig_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      k_q     <= k_d;
      lat_q   <= lat_d;
      poll_q  <= poll_d;
      first_q <= first_d;
      err_q   <= err_d;
      dv_q    <= dv_d;
      rdy_q   <= rdy_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      dig_q   <= dig_d;
    end
  end

  assign bus.IN_READY      = rdy_q;
  assign bus.DIGEST_VALID  = dv_q;
  assign bus.DIGEST        = dig_q;
  assign bus.ERR           = err_q;
  assign bus.AVL_READ      = rd_q;
  assign bus.AVL_WRITE     = wr_q;
  assign bus.AVL_ADDR      = addr_q;
  assign bus.AVL_WRITEDATA = wdata_q;

endmodule
